// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings, FSM state type and constants for alu_mdu.
package alu_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int LUI_HALF       = DEF_DATA_WIDTH / 2;

   // First opcode handled by the iterative multiply/divide unit
   localparam logic [3:0] OP_MULDIV_FIRST = 4'd12;

   typedef enum logic [3:0] {
      OP_AND   = 4'd0,
      OP_OR    = 4'd1,
      OP_ADD   = 4'd2,
      OP_LUI   = 4'd3,
      OP_SLTU  = 4'd4,
      OP_SLL   = 4'd5,
      OP_SUB   = 4'd6,
      OP_SLT   = 4'd7,
      OP_XOR   = 4'd8,
      OP_NOR   = 4'd9,
      OP_SRL   = 4'd10,
      OP_SRA   = 4'd11,
      OP_MULT  = 4'd12,
      OP_MULTU = 4'd13,
      OP_DIV   = 4'd14,
      OP_DIVU  = 4'd15
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_mdu_iter.sv
// alu_mdu_iter: radix-2 iterative multiply / restoring divide on operand
// magnitudes, one bit per cycle, with sign fix-up applied on the final cycle.
// Only built when ALU_MDU_MULDIV_EN is defined.
`ifdef ALU_MDU_MULDIV_EN
module alu_mdu_iter #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic                  is_signed,
   input  logic                  is_div,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo,
   output logic                  dbz
);
   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

   logic             active_q, active_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     hi_q, hi_d, lo_q, lo_d, mag_b_q, mag_b_d, a_q, a_d;
   logic             neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
   logic             div_q, div_d, dbz_q, dbz_d;

   logic [W-1:0]     mag_a, mag_b;
   logic [W:0]       sum_w, shifted, trial;
   logic [2*W-1:0]   prod, prod_neg;

   // Load magnitudes on start, then step one bit per cycle until the counter empties
   always_comb begin
      active_d = active_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      mag_b_d  = mag_b_q;
      a_d      = a_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      div_d    = div_q;
      dbz_d    = dbz_q;
      mag_a    = (is_signed && a[W-1]) ? -a : a;
      mag_b    = (is_signed && b[W-1]) ? -b : b;
      sum_w    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_b_q} : '0);
      shifted  = {hi_q, lo_q[W-1]};
      trial    = shifted - {1'b0, mag_b_q};
      if (start) begin
         active_d = 1'b1;
         cnt_d    = CNT_W'(DATA_WIDTH);
         hi_d     = '0;
         lo_d     = mag_a;
         mag_b_d  = mag_b;
         a_d      = a;
         neg_lo_d = is_signed && (a[W-1] ^ b[W-1]);
         neg_hi_d = is_signed && a[W-1];
         div_d    = is_div;
         dbz_d    = is_div && (b == '0);
      end else if (active_q && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
         if (div_q) begin
            // Restoring step: keep the subtraction only if it did not go negative
            if (!trial[W]) begin
               hi_d = trial[W-1:0];
               lo_d = {lo_q[W-2:0], 1'b1};
            end else begin
               hi_d = shifted[W-1:0];
               lo_d = {lo_q[W-2:0], 1'b0};
            end
         end else begin
            {hi_d, lo_d} = {sum_w, lo_q[W-1:1]};
         end
      end else if (active_q) begin
         active_d = 1'b0;
      end
   end

   // Sign fix-up and divide-by-zero substitution on the raw magnitude result
   always_comb begin
      prod     = {hi_q, lo_q};
      prod_neg = -prod;
      hi       = hi_q;
      lo       = lo_q;
      if (!div_q) begin
         {hi, lo} = neg_lo_q ? prod_neg : prod;
      end else if (dbz_q) begin
         lo = '1;
         hi = a_q;
      end else begin
         lo = neg_lo_q ? -lo_q : lo_q;
         hi = neg_hi_q ? -hi_q : hi_q;
      end
      busy = active_q;
      done = active_q && (cnt_q == '0);
      dbz  = div_q && dbz_q;
   end

   // Control state: cleared by reset so an abandoned operation never completes
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
      end
   end

   // Datapath registers: only meaningful while active, so left unreset
   always_ff @(posedge clk) begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mag_b_q  <= mag_b_d;
      a_q      <= a_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div_q    <= div_d;
      dbz_q    <= dbz_d;
   end

endmodule
`endif

// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU with 16 operations, registered results/flags,
// valid/ready handshake and an optional iterative multiply/divide unit.
// Macro ALU_MDU_MULDIV_EN enables MULT/MULTU/DIV/DIVU; without it those
// opcodes finish in one cycle with a zero result.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            alu_op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic [DATA_WIDTH-1:0] result_hi,
   output logic                  overflow,
   output logic                  carry_out,
   output logic                  zero,
   output logic                  div_by_zero
);
   localparam int W      = DATA_WIDTH;
   localparam int LUI_SH = (LUI_HALF * DATA_WIDTH) / DEF_DATA_WIDTH;

   state_t       state_q, state_d;
   logic [W-1:0] result_q, result_d, hi_q, hi_d;
   logic         ovf_q, ovf_d, cy_q, cy_d, zero_q, zero_d, dbz_q, dbz_d;

   logic signed [W-1:0] a_s, b_s;
   logic [W:0]          sum_ext, diff_ext;
   logic [W-1:0]        alu_res;
   logic                alu_ovf, alu_cy;
   logic                accept, load_alu;

   logic                md_start, md_busy, md_done, md_dbz;
   logic [W-1:0]        md_hi, md_lo;

`ifdef ALU_MDU_MULDIV_EN
   alu_mdu_iter #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_iter (
      .clk      (clk),
      .resetn   (resetn),
      .start    (md_start),
      .is_signed(~alu_op[0]),
      .is_div   (alu_op[1]),
      .a        (a),
      .b        (b),
      .busy     (md_busy),
      .done     (md_done),
      .hi       (md_hi),
      .lo       (md_lo),
      .dbz      (md_dbz)
   );
`else
   assign md_busy = 1'b0;
   assign md_done = 1'b0;
   assign md_dbz  = 1'b0;
   assign md_hi   = '0;
   assign md_lo   = '0;
`endif

   // Single-cycle operation results and ADD/SUB flags
   always_comb begin
      a_s      = signed'(a);
      b_s      = signed'(b);
      sum_ext  = {1'b0, a} + {1'b0, b};
      diff_ext = {1'b0, a} - {1'b0, b};
      alu_res  = '0;
      alu_ovf  = 1'b0;
      alu_cy   = 1'b0;
      case (alu_op_t'(alu_op))
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_ADD: begin
            alu_res = sum_ext[W-1:0];
            alu_cy  = sum_ext[W];
            alu_ovf = (a[W-1] == b[W-1]) && (sum_ext[W-1] != a[W-1]);
         end
         OP_LUI:  alu_res = {b[LUI_SH-1:0], {LUI_SH{1'b0}}};
         OP_SLTU: alu_res = {{(W-1){1'b0}}, (a < b)};
         OP_SLL:  alu_res = b << a[SHAMT_W-1:0];
         OP_SUB: begin
            alu_res = diff_ext[W-1:0];
            alu_cy  = diff_ext[W];
            alu_ovf = (a[W-1] != b[W-1]) && (diff_ext[W-1] != a[W-1]);
         end
         OP_SLT:  alu_res = {{(W-1){1'b0}}, (a_s < b_s)};
         OP_XOR:  alu_res = a ^ b;
         OP_NOR:  alu_res = ~(a | b);
         OP_SRL:  alu_res = b >> a[SHAMT_W-1:0];
         OP_SRA:  alu_res = unsigned'(b_s >>> a[SHAMT_W-1:0]);
         default: alu_res = '0;
      endcase
   end

   // Handshake, next state and output register loads
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      hi_d     = hi_q;
      ovf_d    = ovf_q;
      cy_d     = cy_q;
      zero_d   = zero_q;
      dbz_d    = dbz_q;
      md_start = 1'b0;
      load_alu = 1'b0;
      in_ready = !md_busy &&
                 ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
      accept   = in_valid && in_ready;
      if (accept) begin
`ifdef ALU_MDU_MULDIV_EN
         if (alu_op >= OP_MULDIV_FIRST) begin
            md_start = 1'b1;
            state_d  = ST_BUSY;
         end else begin
            load_alu = 1'b1;
         end
`else
         load_alu = 1'b1;
`endif
      end else begin
         case (state_q)
            ST_BUSY: begin
               if (md_done) begin
                  result_d = md_lo;
                  hi_d     = md_hi;
                  ovf_d    = 1'b0;
                  cy_d     = 1'b0;
                  zero_d   = (md_lo == '0);
                  dbz_d    = md_dbz;
                  state_d  = ST_DONE;
               end
            end
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = state_q;
         endcase
      end
      if (load_alu) begin
         result_d = alu_res;
         hi_d     = '0;
         ovf_d    = alu_ovf;
         cy_d     = alu_cy;
         zero_d   = (alu_res == '0);
         dbz_d    = 1'b0;
         state_d  = ST_DONE;
      end
   end

   // State and registered outputs, all cleared by reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         hi_q     <= '0;
         ovf_q    <= 1'b0;
         cy_q     <= 1'b0;
         zero_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         hi_q     <= hi_d;
         ovf_q    <= ovf_d;
         cy_q     <= cy_d;
         zero_q   <= zero_d;
         dbz_q    <= dbz_d;
      end
   end

   assign out_valid   = (state_q == ST_DONE);
   assign result      = result_q;
   assign result_hi   = hi_q;
   assign overflow    = ovf_q;
   assign carry_out   = cy_q;
   assign zero        = zero_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed vectors against a behavioural model with a scoreboard
// queue; one compare process checks every cycle the outputs are valid.
module tb_alu_mdu;
   localparam int W = 32;
`ifdef ALU_MDU_MULDIV_EN
   localparam int MD_LAT = W + 1;
`else
   localparam int MD_LAT = 1;
`endif

   typedef struct {
      logic [31:0] r;
      logic [31:0] hi;
      logic        ovf;
      logic        cy;
      logic        z;
      logic        dbz;
      int          lat;
      int          acc;
      bit          seen;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_op;
   logic [31:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result, result_hi;
   logic        overflow, carry_out, zero, div_by_zero;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t q[$];

   alu_mdu #(.DATA_WIDTH(W)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_op     (alu_op),
      .a          (a),
      .b          (b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .result_hi  (result_hi),
      .overflow   (overflow),
      .carry_out  (carry_out),
      .zero       (zero),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Behavioural model: outputs straight from the operation definitions
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] ma, input logic [31:0] mb);
      exp_t        e;
      longint      sa, sb, s;
      logic [63:0] u;
      logic [4:0]  sh;
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      sh = ma[4:0];
      e.r = '0; e.hi = '0; e.ovf = 1'b0; e.cy = 1'b0; e.dbz = 1'b0;
      e.lat = 1; e.acc = 0; e.seen = 1'b0;
      case (op)
         4'd0:  e.r = ma & mb;
         4'd1:  e.r = ma | mb;
         4'd2: begin
            u = {32'd0, ma} + {32'd0, mb};
            e.r = u[31:0]; e.cy = u[32];
            s = sa + sb; e.ovf = (s != longint'(int'(s)));
         end
         4'd3:  e.r = {mb[15:0], 16'h0000};
         4'd4:  e.r = (ma < mb) ? 32'd1 : 32'd0;
         4'd5:  e.r = mb << sh;
         4'd6: begin
            e.r = ma - mb; e.cy = (ma < mb);
            s = sa - sb; e.ovf = (s != longint'(int'(s)));
         end
         4'd7:  e.r = (sa < sb) ? 32'd1 : 32'd0;
         4'd8:  e.r = ma ^ mb;
         4'd9:  e.r = ~(ma | mb);
         4'd10: e.r = mb >> sh;
         4'd11: begin s = sb >>> sh; e.r = s[31:0]; end
         default: begin
            e.lat = MD_LAT;
`ifdef ALU_MDU_MULDIV_EN
            if (op == 4'd12) begin
               s = sa * sb; {e.hi, e.r} = s;
            end else if (op == 4'd13) begin
               u = {32'd0, ma} * {32'd0, mb}; {e.hi, e.r} = u;
            end else if (mb == 32'd0) begin
               e.r = 32'hFFFF_FFFF; e.hi = ma; e.dbz = 1'b1;
            end else if (op == 4'd14) begin
               s = sa / sb; e.r = s[31:0];
               s = sa % sb; e.hi = s[31:0];
            end else begin
               u = {32'd0, ma} / {32'd0, mb}; e.r = u[31:0];
               u = {32'd0, ma} % {32'd0, mb}; e.hi = u[31:0];
            end
`endif
         end
      endcase
      e.z = (e.r == 32'd0);
      return e;
   endfunction

   // Scoreboard compare: every valid cycle against the oldest outstanding op
   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
            end else begin
               chk("result", {32'd0, result}, {32'd0, q[0].r});
               chk("result_hi", {32'd0, result_hi}, {32'd0, q[0].hi});
               chk("overflow", {63'd0, overflow}, {63'd0, q[0].ovf});
               chk("carry_out", {63'd0, carry_out}, {63'd0, q[0].cy});
               chk("zero", {63'd0, zero}, {63'd0, q[0].z});
               chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, q[0].dbz});
               chk("in_ready_eq_out_ready", {63'd0, in_ready}, {63'd0, out_ready});
               if (!q[0].seen) begin
                  chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
                  q[0].seen = 1'b1;
               end
               if (out_ready) void'(q.pop_front());
            end
         end else if (q.size() > 0 && cyc > q[0].acc) begin
            chk("in_ready_while_busy", {63'd0, in_ready}, 64'd0);
            if (cyc - q[0].acc >= q[0].lat)
               chk("latency_overrun", 64'(cyc - q[0].acc), 64'(q[0].lat));
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib);
      exp_t e;
      int   n;
      n = 0;
      in_valid = 1'b1; alu_op = op; a = ia; b = ib;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         chk("issue_timeout", {63'd0, in_ready}, 64'd1);
      end else begin
         e = model(op, ia, ib);
         e.acc = cyc;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_outputs_clear(input string tag);
      chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
      chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
      chk({tag, "_result"}, {32'd0, result}, 64'd0);
      chk({tag, "_result_hi"}, {32'd0, result_hi}, 64'd0);
      chk({tag, "_flags"}, {60'd0, overflow, carry_out, zero, div_by_zero}, 64'd0);
   endtask

   initial begin
      exp_t m;
      resetn = 1'b0; in_valid = 1'b0; alu_op = 4'd0; a = '0; b = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_outputs_clear("reset");
      @(posedge clk);
      #1 resetn = 1'b1;

      // Pin the model with hand-computed values
      m = model(4'd2, 32'h7FFF_FFFF, 32'd1);
      chk("model_add", {28'd0, m.ovf, m.cy, m.z, 1'b0, m.r}, {28'd0, 4'b1000, 32'h8000_0000});
      m = model(4'd11, 32'd4, 32'h8000_0010);
      chk("model_sra", {32'd0, m.r}, 64'h0000_0000_F800_0001);
      m = model(4'd5, 32'd33, 32'd1);
      chk("model_sll", {32'd0, m.r}, 64'd2);
      m = model(4'd3, 32'd0, 32'h1234);
      chk("model_lui", {32'd0, m.r}, 64'h0000_0000_1234_0000);
`ifdef ALU_MDU_MULDIV_EN
      m = model(4'd12, 32'hFFFF_FFFD, 32'd7);
      chk("model_mult", {m.hi, m.r}, 64'hFFFF_FFFF_FFFF_FFEB);
      m = model(4'd14, 32'hFFFF_FFF9, 32'd2);
      chk("model_div", {m.hi, m.r}, 64'hFFFF_FFFF_FFFF_FFFD);
      m = model(4'd15, 32'd9, 32'd0);
      chk("model_divu0", {m.hi, m.r}, 64'h0000_0009_FFFF_FFFF);
`else
      m = model(4'd12, 32'hFFFF_FFFD, 32'd7);
      chk("model_mult_off", {m.hi, m.r}, 64'd0);
`endif

      // Single-cycle operations, back-to-back with out_ready high
      issue(4'd2, 32'h7FFF_FFFF, 32'd1);
      issue(4'd6, 32'd5, 32'd5);
      issue(4'd7, 32'hFFFF_FFFF, 32'd1);
      issue(4'd11, 32'd4, 32'h8000_0010);
      issue(4'd5, 32'd33, 32'd1);
      issue(4'd3, 32'hDEAD_BEEF, 32'h0000_1234);
      issue(4'd2, 32'hFFFF_FFFF, 32'd1);
      issue(4'd6, 32'd0, 32'd1);
      issue(4'd6, 32'h8000_0000, 32'd1);
      issue(4'd4, 32'd1, 32'hFFFF_FFFF);
      issue(4'd10, 32'd31, 32'h8000_0000);
      issue(4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF);
      issue(4'd1, 32'hF000_0000, 32'h0000_000F);
      issue(4'd8, 32'hAAAA_5555, 32'hFFFF_0000);
      issue(4'd9, 32'h0000_0000, 32'h0000_0000);
      drain();

      // Multiply / divide (single-cycle zero results when the unit is absent)
      issue(4'd12, 32'hFFFF_FFFD, 32'd7);
      issue(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(4'd14, 32'hFFFF_FFF9, 32'd2);
      issue(4'd15, 32'd9, 32'd0);
      issue(4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(4'd14, 32'd7, 32'hFFFF_FFFE);
      issue(4'd14, 32'd5, 32'd0);
      drain();

      // Consumer stalls for 5 cycles in DONE
      out_ready = 1'b0;
      issue(4'd2, 32'd3, 32'd4);
      repeat (5) @(posedge clk);
      #1 out_ready = 1'b1;
      drain();

      // Reset in the middle of a multiply
      issue(4'd12, 32'd1234, 32'd5678);
      repeat (10) @(posedge clk);
      #1 resetn = 1'b0;
      q.delete();
      @(negedge clk);
      chk_outputs_clear("midreset");
      @(posedge clk);
      #1 resetn = 1'b1;
      issue(4'd2, 32'd1, 32'd2);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
